// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle MIPS-subset core with handshaked instruction/data memories
//
// Purpose: executes one instruction at a time through FETCH/DECODE/EXEC/[MEM]/WB,
// holding memory requests stable across any number of wait states.
// Ports:
//   clk, rst_n                       clock (rising edge), asynchronous active-low reset
//   imem_req/addr/ack/rdata          instruction fetch handshake (word address = pc)
//   dmem_req/we/addr/wdata/ack/rdata data load/store handshake (word address)
//   halted                           high once a HALT opcode has been decoded
//   retire, retire_pc/we/rd/data     one-cycle completion pulse and what it wrote

module multicycle_core #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int NREGS = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            halted,
  output logic            retire,
  output logic [PC_W-1:0] retire_pc,
  output logic            retire_we,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data
);

  localparam int RI = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] OP_R = 6'd0,  OP_J = 6'd2,   OP_JAL = 6'd3,  OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5, OP_ADDI = 6'd8, OP_ORI = 6'd13, OP_LW = 6'd35;
  localparam logic [5:0] OP_ANDI = 6'd36, OP_SW = 6'd43, OP_HALT = 6'h3F;
  localparam logic [5:0] F_SLL = 6'd0, F_SRL = 6'd2, F_JR = 6'd8, F_MUL = 6'd24;
  localparam logic [5:0] F_ADD = 6'd32, F_AND = 6'd36, F_OR = 6'd37, F_NOR = 6'd39, F_SLT = 6'd42;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t state, state_nx;

  logic [PC_W-1:0] pc, npc;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, result;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic            started;   // keeps imem_req low for the first cycle out of reset
  logic [XLEN-1:0] regs [NREGS];

  logic [5:0]  op, funct;
  logic [4:0]  rs_f, rt_f, rd_f, shamt;
  logic [15:0] imm;

  assign op    = ir[31:26];
  assign rs_f  = ir[25:21];
  assign rt_f  = ir[20:16];
  assign rd_f  = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign imm   = ir[15:0];

  // Execute-stage combinational results, registered at the end of EXEC.
  logic [XLEN-1:0] x_res;
  logic [PC_W-1:0] x_npc, pc1, jt;
  logic            x_we;
  logic [4:0]      x_rd;
  logic [XLEN-1:0] sext, zext;
  logic [PC_W-1:0] psext;

  always_comb begin
    sext  = {{(XLEN-16){imm[15]}}, imm};
    zext  = {{(XLEN-16){1'b0}}, imm};
    psext = {{(PC_W-16){imm[15]}}, imm};
    pc1   = pc + 1'b1;
    jt    = pc;
    jt[25:0] = ir[25:0];
    x_res = '0;
    x_npc = pc1;
    x_we  = 1'b0;
    x_rd  = '0;
    case (op)
      OP_R: begin
        x_we = 1'b1;
        x_rd = rd_f;
        case (funct)
          F_ADD:   x_res = a + b;
          F_AND:   x_res = a & b;
          F_OR:    x_res = a | b;
          F_NOR:   x_res = ~(a | b);
          F_MUL:   x_res = a * b;
          F_SLT:   x_res = XLEN'($signed(a) < $signed(b));
          F_SLL:   x_res = b << shamt;
          F_SRL:   x_res = b >> shamt;
          F_JR: begin
            x_we  = 1'b0;
            x_npc = PC_W'(a);
          end
          default: x_we = 1'b0;
        endcase
      end
      OP_ADDI: begin x_we = 1'b1; x_rd = rt_f; x_res = a + sext; end
      OP_ANDI: begin x_we = 1'b1; x_rd = rt_f; x_res = a & zext; end
      OP_ORI:  begin x_we = 1'b1; x_rd = rt_f; x_res = a | zext; end
      OP_LW:   begin x_we = 1'b1; x_rd = rt_f; x_res = a + sext; end
      OP_SW:   x_res = a + sext;
      OP_BEQ:  if (a == b) x_npc = pc1 + psext;
      OP_BNE:  if (a != b) x_npc = pc1 + psext;
      OP_J:    x_npc = jt;
      OP_JAL: begin
        x_npc = jt;
        x_we  = 1'b1;
        x_rd  = 5'd31;
        x_res = XLEN'(pc1);
      end
      default: ;
    endcase
    // r0 is hard-wired: a write aimed at it is dropped and not reported.
    if (x_rd[RI-1:0] == '0) x_we = 1'b0;
    if (!x_we) x_rd = '0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (imem_req && imem_ack) state_nx = S_DECODE;
      S_DECODE: state_nx = (op == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   state_nx = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
      S_MEM:    if (dmem_ack) state_nx = S_WB;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      npc     <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      result  <= '0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      started <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      case (state)
        S_FETCH:  if (imem_req && imem_ack) ir <= imem_rdata;
        S_DECODE: begin
          a <= regs[rs_f[RI-1:0]];
          b <= regs[rt_f[RI-1:0]];
        end
        S_EXEC: begin
          result <= x_res;
          npc    <= x_npc;
          wb_we  <= x_we;
          wb_rd  <= x_rd;
        end
        S_MEM:    if (dmem_ack && op == OP_LW) result <= dmem_rdata;
        S_WB: begin
          if (wb_we) regs[wb_rd[RI-1:0]] <= result;
          pc <= npc;
        end
        default: ;
      endcase
    end
  end

  assign imem_req    = (state == S_FETCH) && started;
  assign imem_addr   = pc;
  assign dmem_req    = (state == S_MEM);
  assign dmem_we     = dmem_req && (op == OP_SW);
  assign dmem_addr   = dmem_req ? result : '0;
  assign dmem_wdata  = dmem_we ? b : '0;
  assign halted      = (state == S_HALT);
  assign retire      = (state == S_WB);
  assign retire_pc   = retire ? pc : '0;
  assign retire_we   = retire && wb_we;
  assign retire_rd   = retire ? wb_rd : '0;
  assign retire_data = retire ? result : '0;

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - directed table-driven bench for multicycle_core

module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        halted, retire, retire_we;
  logic [31:0] retire_pc, retire_data;
  logic [4:0]  retire_rd;

  multicycle_core dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .halted(halted), .retire(retire), .retire_pc(retire_pc), .retire_we(retire_we),
    .retire_rd(retire_rd), .retire_data(retire_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } rec_t;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  vec_t        vecs [$];
  rec_t        log_q [$];
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          iwait = 0, dwait = 0;
  logic        spur = 1'b0;
  int          icnt = 0, dcnt = 0, irun = 0, drun = 0, max_irun = 0, max_drun = 0, stab_err = 0;
  logic        ireq_q = 1'b0, dreq_q = 1'b0;
  logic [31:0] iaddr_q = '0;
  logic [64:0] dq = '0;

  always @(posedge clk) cyc++;

  // Memory responders: ack after the configured number of wait states; with spur set,
  // acks are also driven while the request is low so the core must ignore them.
  always @(negedge clk) begin
    if (!rst_n) begin
      max_irun = 0; max_drun = 0; stab_err = 0;
      for (int i = 0; i < 256; i++) dmem[i] = '0;
      dmem[4] = 32'hA5;
    end
    if (imem_req) begin
      if (ireq_q && !imem_ack && imem_addr !== iaddr_q) stab_err++;
      irun++;
      if (irun > max_irun) max_irun = irun;
      if (icnt == iwait) begin
        imem_ack = 1'b1; imem_rdata = imem[imem_addr[7:0]]; icnt = 0;
      end else begin
        imem_ack = 1'b0; icnt++;
      end
    end else begin
      irun = 0; icnt = 0; imem_ack = spur; imem_rdata = 32'hFC000000;
    end
    ireq_q = imem_req; iaddr_q = imem_addr;
    if (dmem_req) begin
      if (dreq_q && !dmem_ack && {dmem_addr, dmem_we, dmem_wdata} !== dq) stab_err++;
      drun++;
      if (drun > max_drun) max_drun = drun;
      if (dcnt == dwait) begin
        dmem_ack = 1'b1; dcnt = 0;
        if (dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
        else dmem_rdata = dmem[dmem_addr[7:0]];
      end else begin
        dmem_ack = 1'b0; dcnt++;
      end
    end else begin
      drun = 0; dcnt = 0; dmem_ack = spur; dmem_rdata = 32'hDEADBEEF;
    end
    dreq_q = dmem_req; dq = {dmem_addr, dmem_we, dmem_wdata};
  end

  always @(negedge clk) begin
    if (!rst_n) log_q.delete();
    else if (retire) log_q.push_back('{retire_pc, retire_we, retire_rd, retire_data, cyc});
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] pc, input logic [31:0] ins, input logic we,
                     input logic [4:0] rd, input logic [31:0] data, input int lat);
    imem[pc[7:0]] = ins;
    vecs.push_back('{pc, we, rd, data, lat});
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = '0;
  endtask

  task automatic wait_retires(input int n, input int budget);
    for (int k = 0; k < budget && log_q.size() < n; k++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  int nreq;

  initial begin
    rst_n = 1'b0;
    spur  = 1'b1;
    clear_imem();
    add(32'd0,  enc_i(6'd8, 5'd0, 5'd1, 16'd5),                1, 5'd1,  32'd5,        4);
    add(32'd1,  enc_i(6'd8, 5'd0, 5'd2, 16'hFFFD),             1, 5'd2,  32'hFFFFFFFD, 4);
    add(32'd2,  enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'd32),          1, 5'd3,  32'd2,        4);
    add(32'd3,  enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'd42),          1, 5'd4,  32'd1,        4);
    add(32'd4,  enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'd39),          1, 5'd5,  32'd2,        4);
    add(32'd5,  enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'd24),          1, 5'd6,  32'hFFFFFFF1, 4);
    add(32'd6,  enc_r(5'd0, 5'd1, 5'd7, 5'd4, 6'd0),           1, 5'd7,  32'h50,       4);
    add(32'd7,  enc_r(5'd0, 5'd2, 5'd8, 5'd28, 6'd2),          1, 5'd8,  32'hF,        4);
    add(32'd8,  enc_i(6'd36, 5'd2, 5'd9, 16'hFF0F),            1, 5'd9,  32'h0000FF0D, 4);
    add(32'd9,  enc_i(6'd13, 5'd0, 5'd10, 16'h8000),           1, 5'd10, 32'h00008000, 4);
    add(32'd10, enc_i(6'd4, 5'd1, 5'd1, 16'd2),                0, 5'd0,  32'd0,        4);
    add(32'd13, enc_i(6'd5, 5'd1, 5'd1, 16'd2),                0, 5'd0,  32'd0,        4);
    add(32'd14, enc_i(6'd43, 5'd0, 5'd3, 16'd8),               0, 5'd0,  32'd0,        5);
    add(32'd15, enc_i(6'd35, 5'd0, 5'd11, 16'd8),              1, 5'd11, 32'd2,        5);
    add(32'd16, enc_j(6'd3, 26'h40),                           1, 5'd31, 32'd17,       4);
    add(32'h40, enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'd8),          0, 5'd0,  32'd0,        4);
    add(32'd17, enc_i(6'd8, 5'd0, 5'd0, 16'd7),                0, 5'd0,  32'd0,        4);
    add(32'd18, enc_i(6'd8, 5'd0, 5'd12, 16'd1),               1, 5'd12, 32'd1,        4);
    add(32'd19, enc_i(6'h3E, 5'd1, 5'd13, 16'd1),              0, 5'd0,  32'd0,        4);
    add(32'd20, enc_j(6'd2, 26'd22),                           0, 5'd0,  32'd0,        4);
    add(32'd22, enc_i(6'd4, 5'd1, 5'd2, 16'd5),                0, 5'd0,  32'd0,        4);
    add(32'd23, enc_r(5'd1, 5'd2, 5'd13, 5'd0, 6'd36),         1, 5'd13, 32'd5,        4);
    add(32'd24, enc_r(5'd1, 5'd2, 5'd14, 5'd0, 6'd37),         1, 5'd14, 32'hFFFFFFFD, 4);
    add(32'd25, enc_r(5'd2, 5'd2, 5'd15, 5'd0, 6'd32),         1, 5'd15, 32'hFFFFFFFA, 4);
    imem[11] = enc_i(6'd8, 5'd0, 5'd20, 16'd99);
    imem[12] = enc_i(6'd8, 5'd0, 5'd20, 16'd99);
    imem[21] = enc_i(6'd8, 5'd0, 5'd20, 16'd99);
    imem[26] = 32'hFC000000;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_retire_pc", retire_pc, 0);
    chk("rst_halted", halted, 0);
    #1 rst_n = 1'b1;

    wait_retires(vecs.size(), 400);
    chk("t1_retire_count", log_q.size(), vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      if (i >= log_q.size()) begin
        chk($sformatf("v%0d_missing", i), 0, 1);
      end else begin
        chk($sformatf("v%0d_pc", i), log_q[i].pc, vecs[i].pc);
        chk($sformatf("v%0d_we", i), log_q[i].we, vecs[i].we);
        if (vecs[i].we) begin
          chk($sformatf("v%0d_rd", i), log_q[i].rd, vecs[i].rd);
          chk($sformatf("v%0d_data", i), log_q[i].data, vecs[i].data);
        end
        if (i > 0) chk($sformatf("v%0d_lat", i), log_q[i].cyc - log_q[i-1].cyc, vecs[i].lat);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    chk("t5_halted", halted, 1);
    nreq = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (imem_req) nreq++;
    end
    chk("t5_no_fetch_after_halt", nreq, 0);
    chk("t5_no_extra_retire", log_q.size(), vecs.size());
    chk("t1_req_stability", stab_err, 0);

    // Three wait states on both memories.
    spur = 1'b0; iwait = 3; dwait = 3;
    clear_imem();
    imem[0] = enc_i(6'd8, 5'd0, 5'd1, 16'd1);
    imem[1] = enc_i(6'd35, 5'd0, 5'd5, 16'd4);
    imem[2] = 32'hFC000000;
    do_reset();
    wait_retires(2, 200);
    chk("t2_retire_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("t2_addi_data", log_q[0].data, 1);
      chk("t2_lw_pc", log_q[1].pc, 1);
      chk("t2_lw_we", log_q[1].we, 1);
      chk("t2_lw_rd", log_q[1].rd, 5);
      chk("t2_lw_data", log_q[1].data, 32'hA5);
      chk("t2_lw_interval", log_q[1].cyc - log_q[0].cyc, 11);
    end
    chk("t2_imem_req_len", max_irun, 4);
    chk("t2_dmem_req_len", max_drun, 4);
    chk("t2_req_stability", stab_err, 0);

    // Reset while a load is waiting on the data memory.
    iwait = 0; dwait = 20;
    imem[1] = enc_i(6'd35, 5'd0, 5'd6, 16'd4);
    do_reset();
    for (int k = 0; k < 60 && !dmem_req; k++) @(negedge clk);
    #2;
    chk("t6_dmem_req_seen", dmem_req, 1);
    chk("t6_pre_retires", log_q.size(), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_dmem_req_drop", dmem_req, 0);
    chk("t6_imem_req_rst", imem_req, 0);
    chk("t6_imem_addr_rst", imem_addr, 0);
    chk("t6_retire_rst", retire, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 20 && !imem_req; k++) begin
      @(negedge clk); #1;
    end
    chk("t6_first_fetch_req", imem_req, 1);
    chk("t6_first_fetch_addr", imem_addr, 0);
    chk("t6_dmem_abandoned", dmem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
